// File: rtl/sar_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_ctrl
// Purpose  : SAR control stage: sample phase, flag-paced MSB-first bit trials,
//            valid/ready result hand-off. Optional macro: SAR_OVERRUN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sar_ctrl #(
    parameter int NBITS         = 12,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             CMP,
    input  logic [NBITS-1:0] FLAG,
    output logic             FLAG_RST,
    output logic             SAMPLE,
    output logic             BUSY,
    output logic [NBITS-1:0] DAC,
    output logic [NBITS-1:0] DATA,
    output logic             VALID,
    input  logic             READY,
    output logic             OVR
);

    localparam int SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int STW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [SCW-1:0]   c_SAMPLE_LOAD = SCW'(SAMPLE_CYCLES - 1);
    localparam logic [STW-1:0]   c_LAST_STEP   = STW'(NBITS - 1);
    localparam logic [NBITS-1:0] c_DAC_MSB     = NBITS'(1) << (NBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAMPLE  = 2'd1,
        S_CONVERT = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [SCW-1:0]   r_cnt, w_cnt_nxt;
    logic [STW-1:0]   r_step, w_step_nxt;
    logic             r_flag_rst, w_flag_rst_nxt;
    logic             r_sample, w_sample_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_valid, w_valid_nxt;
    logic [NBITS-1:0] r_dac, w_dac_nxt;
    logic [NBITS-1:0] r_data, w_data_nxt;
    logic [STW-1:0]   w_bit;
    logic             w_done;
    logic [NBITS-1:0] w_code;
`ifdef SAR_OVERRUN_EN
    logic             r_ovr, w_ovr_nxt;
`endif

    assign w_bit  = c_LAST_STEP - r_step;
    assign w_code = {r_dac[NBITS-1:1], CMP};

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_step_nxt     = r_step;
        w_flag_rst_nxt = r_flag_rst;
        w_sample_nxt   = r_sample;
        w_busy_nxt     = r_busy;
        w_dac_nxt      = r_dac;
        w_data_nxt     = r_data;
        w_valid_nxt    = r_valid;
        w_done         = 1'b0;
`ifdef SAR_OVERRUN_EN
        w_ovr_nxt      = r_ovr;
`endif
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt  = S_SAMPLE;
                    w_sample_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_dac_nxt    = '0;
                    w_cnt_nxt    = c_SAMPLE_LOAD;
                end
            end
            S_SAMPLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt    = S_CONVERT;
                    w_sample_nxt   = 1'b0;
                    w_flag_rst_nxt = 1'b0;
                    w_dac_nxt      = c_DAC_MSB;
                    w_step_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt - SCW'(1);
                end
            end
            S_CONVERT: begin
                // Only the flag bit matching the current step paces a decision.
                if (FLAG[r_step]) begin
                    if (r_step == c_LAST_STEP) begin
                        w_done         = 1'b1;
                        w_state_nxt    = S_IDLE;
                        w_flag_rst_nxt = 1'b1;
                        w_busy_nxt     = 1'b0;
                        w_dac_nxt      = '0;
                    end else begin
                        w_dac_nxt[w_bit]          = CMP;
                        w_dac_nxt[w_bit - STW'(1)] = 1'b1;
                        w_step_nxt                = r_step + STW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (r_valid && READY)
            w_valid_nxt = 1'b0;
        if (w_done) begin
`ifdef SAR_OVERRUN_EN
            // Unread result with no accept this edge: keep it, flag the loss.
            if (r_valid && !READY) begin
                w_ovr_nxt = 1'b1;
            end else begin
                w_data_nxt  = w_code;
                w_valid_nxt = 1'b1;
            end
`else
            w_data_nxt  = w_code;
            w_valid_nxt = 1'b1;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_step     <= '0;
            r_flag_rst <= 1'b1;
            r_sample   <= 1'b0;
            r_busy     <= 1'b0;
            r_dac      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_step     <= w_step_nxt;
            r_flag_rst <= w_flag_rst_nxt;
            r_sample   <= w_sample_nxt;
            r_busy     <= w_busy_nxt;
            r_dac      <= w_dac_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

`ifdef SAR_OVERRUN_EN
    always_ff @(posedge CLK) begin
        if (RST)
            r_ovr <= 1'b0;
        else
            r_ovr <= w_ovr_nxt;
    end
    assign OVR = r_ovr;
`else
    assign OVR = 1'b0;
`endif

    assign FLAG_RST = r_flag_rst;
    assign SAMPLE   = r_sample;
    assign BUSY     = r_busy;
    assign DAC      = r_dac;
    assign DATA     = r_data;
    assign VALID    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_sar_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_ctrl
// Purpose  : Self-checking bench for sar_ctrl with a flag generator model,
//            ideal/stuck comparator and a timing-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_ctrl;

    localparam int NB = 12;
    localparam int SC = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          READY = 1'b0;
    logic          CMP;
    logic [NB-1:0] FLAG;
    logic          FLAG_RST, SAMPLE, BUSY, VALID, OVR;
    logic [NB-1:0] DAC, DATA;

    sar_ctrl #(.NBITS(NB), .SAMPLE_CYCLES(SC)) dut (
        .CLK(CLK), .RST(RST), .START(START), .CMP(CMP), .FLAG(FLAG),
        .FLAG_RST(FLAG_RST), .SAMPLE(SAMPLE), .BUSY(BUSY), .DAC(DAC),
        .DATA(DATA), .VALID(VALID), .READY(READY), .OVR(OVR)
    );

    always #5 CLK = ~CLK;

    // Flag generator: shifts in one '1' per clock while released; stall freezes it.
    logic [NB-1:0] flag_q = '0;
    logic          stall  = 1'b0;
    always @(posedge CLK) begin
        if (FLAG_RST !== 1'b0) flag_q <= '0;
        else if (!stall)       flag_q <= {flag_q[NB-2:0], 1'b1};
    end
    assign FLAG = flag_q;

    // Comparator: mode 0 ideal against vin, 1 stuck high, 2 stuck low.
    int            mode = 0;
    logic [NB-1:0] vin  = '0;
    assign CMP = (mode == 0) ? (vin >= DAC) : (mode == 1);

    function automatic logic [NB-1:0] target();
        if (mode == 0) return vin;
        if (mode == 1) return '1;
        return '0;
    endfunction

    int n_chk  = 0;
    int n_pass = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: conversion timeline, SAR partial codes from the final answer.
    int            m_phase = 0;   // 0 idle, 1 sampling, 2 converting
    int            m_t     = 0;
    int            m_dec   = 0;
    logic          e_sample = 1'b0, e_busy = 1'b0, e_flag_rst = 1'b1;
    logic          e_valid = 1'b0, e_ovr = 1'b0;
    logic [NB-1:0] e_dac = '0, e_data = '0;
    logic          m_v0, m_fire;
    logic [NB-1:0] m_keep;

    always @(posedge CLK) begin
        if (RST) begin
            m_phase = 0; m_t = 0; m_dec = 0;
            e_sample = 0; e_busy = 0; e_flag_rst = 1; e_valid = 0; e_ovr = 0;
            e_dac = '0; e_data = '0;
        end else begin
            m_fire = 1'b0;
            m_v0   = e_valid;
            if (e_valid && READY) e_valid = 1'b0;
            if (m_phase == 0) begin
                if (START) begin
                    m_phase = 1; m_t = 0; e_sample = 1; e_busy = 1; e_dac = '0;
                end
            end else if (m_phase == 1) begin
                m_t++;
                if (m_t == SC) begin
                    m_phase = 2; m_dec = 0; e_sample = 0; e_flag_rst = 0;
                    e_dac = NB'(1) << (NB - 1);
                end
            end else begin
                if ($countones(FLAG) > m_dec) begin
                    m_dec++;
                    if (m_dec == NB) begin
                        m_phase = 0; e_busy = 0; e_flag_rst = 1; e_dac = '0; m_fire = 1'b1;
                    end else begin
                        m_keep = ~((NB'(1) << (NB - m_dec)) - NB'(1));
                        e_dac  = (target() & m_keep) | (NB'(1) << (NB - 1 - m_dec));
                    end
                end
            end
            if (m_fire) begin
`ifdef SAR_OVERRUN_EN
                if (m_v0 && !READY) e_ovr = 1'b1;
                else begin e_data = target(); e_valid = 1'b1; end
`else
                e_data = target(); e_valid = 1'b1;
`endif
            end
        end
    end

    logic chk_en = 1'b0;
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_SAMPLE",   32'(SAMPLE),   32'(e_sample));
            chk("m_BUSY",     32'(BUSY),     32'(e_busy));
            chk("m_FLAG_RST", 32'(FLAG_RST), 32'(e_flag_rst));
            chk("m_DAC",      32'(DAC),      32'(e_dac));
            chk("m_DATA",     32'(DATA),     32'(e_data));
            chk("m_VALID",    32'(VALID),    32'(e_valid));
            chk("m_OVR",      32'(OVR),      32'(e_ovr));
        end
    end

    logic [NB-1:0] dac_seq [0:63];

    // Runs one conversion from a START edge; n = edges from START edge to BUSY drop.
    task automatic conv(input bit hold, input int stall_at, output int n);
        START = 1'b1;
        @(posedge CLK); #1;
        n = 0;
        dac_seq[0] = DAC;
        if (!hold) START = 1'b0;
        while (n < 60) begin
            if (n == stall_at)     stall = 1'b1;
            if (n == stall_at + 3) stall = 1'b0;
            @(posedge CLK); #1;
            n++;
            dac_seq[n] = DAC;
            if (!BUSY) break;
        end
        stall = 1'b0;
    endtask

    task automatic reset_dut();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    int lat;

    initial begin
        @(posedge CLK); #1 chk_en = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;

        // Reset and idle
        repeat (20) @(posedge CLK);
        #1;
        chk("idle_FLAG_RST", 32'(FLAG_RST), 32'd1);
        chk("idle_BUSY",     32'(BUSY),     32'd0);
        chk("idle_DAC",      32'(DAC),      32'd0);
        chk("idle_VALID",    32'(VALID),    32'd0);

        // Ideal conversion
        READY = 1'b1; mode = 0; vin = 12'hA5C;
        conv(1'b0, -1, lat);
        chk("ideal_lat",   32'(lat),        32'd15);
        chk("ideal_data",  32'(DATA),       32'hA5C);
        chk("ideal_valid", 32'(VALID),      32'd1);
        chk("ideal_dac0",  32'(dac_seq[2]), 32'h800);
        chk("ideal_dac1",  32'(dac_seq[4]), 32'hC00);
        chk("ideal_dac2",  32'(dac_seq[5]), 32'hA00);

        // Extremes
        mode = 1;
        conv(1'b0, -1, lat);
        chk("ones_lat",  32'(lat),  32'd15);
        chk("ones_data", 32'(DATA), 32'hFFF);
        mode = 2;
        conv(1'b0, -1, lat);
        chk("zero_lat",  32'(lat),  32'd15);
        chk("zero_data", 32'(DATA), 32'h000);

        // Backpressure with back-to-back conversions
        reset_dut();
        READY = 1'b0; mode = 0; vin = 12'h123;
        conv(1'b1, -1, lat);
        chk("bp1_lat", 32'(lat), 32'd15);
        vin = 12'h456;
        conv(1'b0, -1, lat);
        chk("bp2_lat",   32'(lat),   32'd15);
        chk("bp_valid",  32'(VALID), 32'd1);
`ifdef SAR_OVERRUN_EN
        chk("bp_data",   32'(DATA),  32'h123);
        chk("bp_ovr",    32'(OVR),   32'd1);
`else
        chk("bp_data",   32'(DATA),  32'h456);
        chk("bp_ovr",    32'(OVR),   32'd0);
`endif
        READY = 1'b1;
        @(posedge CLK); #1 READY = 1'b0;
        chk("bp_accept", 32'(VALID), 32'd0);

        // Same-edge completion and accept
        reset_dut();
        vin = 12'h321;
        conv(1'b0, -1, lat);
        vin = 12'h654;
        START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        repeat (14) @(posedge CLK);
        #1 READY = 1'b1;
        @(posedge CLK); #1 READY = 1'b0;
        chk("same_done",  32'(BUSY),  32'd0);
        chk("same_valid", 32'(VALID), 32'd1);
        chk("same_ovr",   32'(OVR),   32'd0);
        chk("same_data",  32'(DATA),  32'h654);

        // Abort at decision 5 with a pending result, then restart
        vin = 12'h0F0;
        START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        repeat (8) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        chk("abort_busy",     32'(BUSY),     32'd0);
        chk("abort_dac",      32'(DAC),      32'd0);
        chk("abort_flag_rst", 32'(FLAG_RST), 32'd1);
        chk("abort_valid",    32'(VALID),    32'd0);
        chk("abort_data",     32'(DATA),     32'd0);
        READY = 1'b1; vin = 12'h7E1;
        conv(1'b0, -1, lat);
        chk("restart_lat",  32'(lat),  32'd15);
        chk("restart_data", 32'(DATA), 32'h7E1);

        // Flag stall of 3 clocks mid-conversion
        vin = 12'h3C9;
        conv(1'b0, 7, lat);
        chk("stall_lat",  32'(lat),  32'd18);
        chk("stall_data", 32'(DATA), 32'h3C9);

        repeat (3) @(posedge CLK);
        #1 chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
